// File: rtl/systolic_array_nxn.sv
// N x N weight-stationary systolic matmul: skews rows in, deskews columns out,
// double-buffers weights behind a drain-safe switch and masks columns at the output.
module systolic_array_nxn #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int CS_W   = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*DATA_W-1:0] sys_data_in,
  input  logic                sys_valid_in,
  output logic                sys_ready,
  input  logic [N*DATA_W-1:0] sys_weight_in,
  input  logic                sys_weight_load,
  input  logic                sys_weight_switch,
  output logic                sys_switch_pending,
  input  logic [CS_W-1:0]     sys_col_size_in,
  input  logic                sys_col_size_valid_in,
  output logic [N*DATA_W-1:0] sys_data_out,
  output logic [N-1:0]        sys_valid_out,
  output logic                sys_busy
);
  localparam int LAT   = 2 * N;
  localparam int CNT_W = $clog2(2 * N + 1);

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  state_t state_q, state_d;
  logic   copy_en;
  logic   accept;
  logic   exit_v;

  logic signed [DATA_W-1:0] shadow_q [N][N];
  logic signed [DATA_W-1:0] shadow_d [N][N];
  logic signed [DATA_W-1:0] active_q [N][N];
  logic signed [DATA_W-1:0] active_d [N][N];

  logic [N-1:0]      mask_q, mask_d;
  logic [LAT-1:0]    vpipe_q, vpipe_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]      valid_out_q, valid_out_d;
  logic [DATA_W-1:0] data_out_q [N];
  logic [DATA_W-1:0] data_out_d [N];

  logic signed [DATA_W-1:0] x_in    [N][N];
  logic signed [DATA_W-1:0] psum    [N][N];
  logic [DATA_W-1:0]        col_res [N];

  assign sys_ready          = (state_q == S_IDLE);
  assign sys_switch_pending = (state_q == S_PENDING);
  assign sys_busy           = (cnt_q != '0);
  assign accept             = sys_valid_in && sys_ready;
  assign exit_v             = vpipe_q[LAT-1];
  assign sys_valid_out      = valid_out_q;

  // The active bank is only rewritten while nothing is in flight.
  always_comb begin
    state_d = state_q;
    copy_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sys_weight_switch) begin
          if (sys_busy) state_d = S_PENDING;
          else          copy_en = 1'b1;
        end
      end
      S_PENDING: begin
        if (!sys_busy) begin
          copy_en = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (sys_weight_load) begin
      for (int r = N - 1; r > 0; r--) shadow_d[r] = shadow_q[r-1];
      for (int c = 0; c < N; c++) shadow_d[0][c] = sys_weight_in[c*DATA_W +: DATA_W];
    end
    if (copy_en) active_d = shadow_q;
  end

  always_comb begin
    vpipe_d = {vpipe_q[LAT-2:0], accept};
    cnt_d   = cnt_q;
    if (accept && !exit_v)      cnt_d = cnt_q + 1'b1;
    else if (!accept && exit_v) cnt_d = cnt_q - 1'b1;
    mask_d = mask_q;
    if (sys_col_size_valid_in) begin
      for (int j = 0; j < N; j++) mask_d[j] = (32'(sys_col_size_in) > j);
    end
    for (int j = 0; j < N; j++) begin
      valid_out_d[j] = mask_q[j] & exit_v;
      data_out_d[j]  = mask_q[j] ? col_res[j] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      vpipe_q     <= '0;
      cnt_q       <= '0;
      valid_out_q <= '0;
      for (int r = 0; r < N; r++) begin
        data_out_q[r] <= '0;
        for (int c = 0; c < N; c++) begin
          shadow_q[r][c] <= '0;
          active_q[r][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      vpipe_q     <= vpipe_d;
      cnt_q       <= cnt_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  genvar gi, gj;
  generate
    // Lane gi waits gi extra cycles so its element meets the right partial sum.
    for (gi = 0; gi < N; gi++) begin : g_skew
      logic [DATA_W-1:0] sk_q [gi+1];
      logic [DATA_W-1:0] sk_d [gi+1];
      always_comb begin
        sk_d[0] = accept ? sys_data_in[gi*DATA_W +: DATA_W] : '0;
        for (int m = 1; m <= gi; m++) sk_d[m] = sk_q[m-1];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int m = 0; m <= gi; m++) sk_q[m] <= '0;
        end else begin
          sk_q <= sk_d;
        end
      end
      assign x_in[gi][0] = sk_q[gi];
    end

    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic signed [2*DATA_W-1:0] prod;
        logic signed [DATA_W-1:0]   term;
        logic signed [DATA_W-1:0]   psum_above;
        logic signed [DATA_W-1:0]   psum_q, psum_d;

        assign prod = x_in[gi][gj] * active_q[gi][gj];
        assign term = DATA_W'(prod >>> FRAC_W);
        if (gi == 0) begin : g_top
          assign psum_above = '0;
        end else begin : g_mid
          assign psum_above = psum[gi-1][gj];
        end
        always_comb psum_d = psum_above + term;
        always_ff @(posedge clk) begin
          if (rst) psum_q <= '0;
          else     psum_q <= psum_d;
        end
        assign psum[gi][gj] = psum_q;

        if (gj < N - 1) begin : g_pass
          logic signed [DATA_W-1:0] x_q, x_d;
          always_comb x_d = x_in[gi][gj];
          always_ff @(posedge clk) begin
            if (rst) x_q <= '0;
            else     x_q <= x_d;
          end
          assign x_in[gi][gj+1] = x_q;
        end
      end
    end

    // Earlier columns finish sooner; delay them so all lanes leave together.
    for (gj = 0; gj < N; gj++) begin : g_deskew
      localparam int D = N - 1 - gj;
      if (D == 0) begin : g_none
        assign col_res[gj] = psum[N-1][gj];
      end else begin : g_dly
        logic [DATA_W-1:0] dq_q [D];
        logic [DATA_W-1:0] dq_d [D];
        always_comb begin
          dq_d[0] = psum[N-1][gj];
          for (int m = 1; m < D; m++) dq_d[m] = dq_q[m-1];
        end
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int m = 0; m < D; m++) dq_q[m] <= '0;
          end else begin
            dq_q <= dq_d;
          end
        end
        assign col_res[gj] = dq_q[D-1];
      end
    end

    for (gj = 0; gj < N; gj++) begin : g_out
      assign sys_data_out[gj*DATA_W +: DATA_W] = data_out_q[gj];
    end
  endgenerate
endmodule

// File: doc/systolic_array_nxn.md
Name: systolic_array_nxn

Overview:
Parametrised N x N weight-stationary systolic matrix-multiply array. It is the successor to the fixed 2x2 array.
- Adds internal input skew and output deskew, so callers present whole unskewed row vectors and receive aligned result vectors.
- Adds double-buffered weights with a drain-safe switch handshake, and a runtime column-enable mask.
- Sits between the unified buffer read path (data, weights, column size) and the accumulator/activation stage.

Parameters:
N, 4, array dimension (rows = columns = N), N >= 2
DATA_W, 16, two's-complement width of data, weights and partial sums
FRAC_W, 8, fractional bits of the fixed-point format (Q(DATA_W-FRAC_W).FRAC_W)
CS_W, $clog2(N+1), width of the column-size field

Ports:
clk  in  1  clock
rst  in  1  reset
sys_data_in  in  N*DATA_W  input row vector; lane i (bits i*DATA_W +: DATA_W) feeds array row i
sys_valid_in  in  1  vector valid; accepted when sys_valid_in && sys_ready
sys_ready  out  1  array can accept a vector this cycle
sys_weight_in  in  N*DATA_W  weight row; lane j feeds column j
sys_weight_load  in  1  shift sys_weight_in into the shadow weight bank
sys_weight_switch  in  1  request copy of shadow bank into active bank
sys_switch_pending  out  1  switch requested, not yet applied
sys_col_size_in  in  CS_W  number of enabled columns
sys_col_size_valid_in  in  1  load sys_col_size_in
sys_data_out  out  N*DATA_W  result vector; lane j = column j
sys_valid_out  out  N  per-column result valid
sys_busy  out  1  at least one accepted vector still in flight

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high: all registers are cleared on the clk edge while rst=1.
- Reset values: sys_data_out=0, sys_valid_out=0, sys_busy=0, sys_switch_pending=0, sys_ready=1 (first cycle after reset), both weight banks=0, column mask=0 (all columns disabled).
- Reset mid-operation discards in-flight vectors, any pending switch and both weight banks.
- Datapath function: result lane j = sum over i of ((x_i * Wa[i][j]) >>> FRAC_W).
  - Full 2*DATA_W signed product; arithmetic shift right by FRAC_W; truncate to DATA_W.
  - Accumulation wraps modulo 2^DATA_W (no saturation).
- Skew: lane i is delayed i cycles before entering PE(i,0).
  - Each PE registers input (passed right) and psum (passed down): one cycle per hop.
  - Column j's result is delayed N-1-j cycles, then passes through one output register.
- Latency: a vector accepted on edge k appears on all lanes of sys_data_out, with its valid bits set, exactly 2N cycles later (N=2: 4 cycles).
- Throughput is one vector per cycle. Back-to-back vectors never interleave.
- Column mask: on sys_col_size_valid_in, mask <= (1<<min(size,N))-1. The mask takes effect from the next cycle.
  - The mask is applied at the output register only.
  - Disabled column: sys_valid_out[j]=0 and lane j=0.
  - Enabled column: sys_valid_out[j] = aligned valid.
  - Changing the mask mid-stream affects only results emitted after the change.
- Weight load: sys_weight_load shifts the shadow bank down one row (new row enters row 0, row N-1 drops).
  - After N loads, the first-loaded row sits in row N-1.
  - Loads are allowed at any time. They never disturb the active bank.
- Switch state machine:
  - IDLE: if sys_weight_switch && !sys_busy, copy shadow->active on that edge and stay IDLE. If sys_weight_switch && sys_busy, go to PENDING.
  - PENDING: sys_switch_pending=1; sys_ready=0. Vectors are not accepted; sys_valid_in is ignored.
  - PENDING: the first edge on which sys_busy=0, copy shadow->active and return to IDLE.
  - Additional switch requests while PENDING are merged into the pending one.
  - Simultaneous load and switch on the same edge: the copy takes the pre-load shadow contents.
- sys_ready = !sys_switch_pending.
- sys_busy is driven by an in-flight counter of width $clog2(2N+1):
  - +1 on accept, -1 when a vector exits; simultaneous accept and exit leaves it unchanged.
  - sys_busy = (count != 0).
- Accepted vectors always use the active bank present at their acceptance. This is guaranteed because a switch only occurs when the array is empty.

Test Plan:
1. Identity, N=2, FRAC_W=8, mask=2: load rows [0x0000,0x0100] then [0x0100,0x0000] (row0=[0x0100,0], row1=[0,0x0100]), switch, input [0x0300,0xFE00] -> 4 cycles later out=[0x0300,0xFE00], valid=2'b11.
2. General matrix: load [0x0300,0x0400] then [0x0100,0x0200], switch, input [0x0100,0x0100] -> out=[0x0400,0x0600]; 3 back-to-back vectors -> 3 consecutive aligned outputs.
3. Deferred switch: stream vectors, assert switch while busy -> sys_switch_pending=1 and sys_ready=0 until drain; in-flight results use old weights; first vector after drain uses new weights.
4. Column mask: mask size=1 with N=2 -> sys_valid_out=2'b01 and lane 1 = 0; size=3 (>N) clamps to 2'b11; size=0 -> all valid low.
5. Wrap: weight 0x7F00, input 0x0200 in two rows of column 0 -> result truncated modulo 2^16 (0xFC00), no saturation.
6. Reset mid-stream: rst for one cycle with 2 vectors in flight and switch pending -> next cycle valid_out=0, busy=0, pending=0, ready=1; a subsequent vector with zero weights yields 0.
